// File: rtl/fc_quant_pkg.sv
// Shared types and config for the FC requantization stage.
// Widths follow the MAC datapath: 32-bit accumulators, int8 activations.
package fc_quant_pkg;

    localparam int ACC_W     = 32;
    localparam int OUT_W     = 8;
    localparam int CNT_W     = 16;
    localparam int SHIFT_MIN = -31;
    localparam int SHIFT_MAX = 30;

    typedef logic signed [ACC_W-1:0]   acc_t;
    typedef logic signed [2*ACC_W-1:0] prod_t;
    typedef logic signed [OUT_W-1:0]   q8_t;

    typedef struct packed {
        logic             relu_en;
        acc_t             mult;
        acc_t             shift;
        q8_t              out_zp;
        logic [CNT_W-1:0] count;
    } fc_cfg_t;

    localparam fc_cfg_t CFG_RST = '{
        relu_en: 1'b1,
        mult:    '0,
        shift:   '0,
        out_zp:  '0,
        count:   CNT_W'(1)
    };

    function automatic logic cfg_legal(input fc_cfg_t c);
        return ($signed(c.shift) >= SHIFT_MIN)
            && ($signed(c.shift) <= SHIFT_MAX)
            && (c.count != '0);
    endfunction

endpackage

// File: rtl/fc_round_shift.sv
// Round-half-up arithmetic right shift of a 64-bit product by (31 - shift).
// Out-of-range shifts are clamped so the shifter never sees 0 or >62.
module fc_round_shift
    import fc_quant_pkg::*;
(
    input  prod_t       p_i,
    input  acc_t        shift_i,
    output logic [15:0] q_o
);

    logic signed [ACC_W:0] ts_full;
    logic [5:0]            ts;
    prod_t                 rnd;
    prod_t                 sum;
    prod_t                 q;

    always_comb begin
        ts_full = 33'sd31 - $signed({shift_i[ACC_W-1], shift_i});
        if (ts_full < 33'sd1) begin
            ts = 6'd1;
        end else if (ts_full > 33'sd62) begin
            ts = 6'd62;
        end else begin
            ts = ts_full[5:0];
        end
        rnd = prod_t'(64'sd1) <<< (ts - 6'd1);
        sum = p_i + rnd;
        q   = sum >>> ts;
        q_o = q[15:0];
    end

endmodule

// File: rtl/fc_requant_stage.sv
// Bias + ReLU + requantize pipeline: acc32 in, int8 activation out.
// Three registered stages under one global stall; o_last marks layer end.
module fc_requant_stage
    import fc_quant_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [ACC_W-1:0] i_acc,
    input  logic [ACC_W-1:0] i_bias,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_last,
    input  logic             i_cfg_load,
    input  logic             i_cfg_relu_en,
    input  logic [ACC_W-1:0] i_cfg_mult,
    input  logic [ACC_W-1:0] i_cfg_shift,
    input  logic [OUT_W-1:0] i_cfg_out_zp,
    input  logic [CNT_W-1:0] i_cfg_count,
    output logic             o_busy,
    output logic             o_cfg_err
);

    logic             v1_q, v2_q, v3_q;
    acc_t             r1_q, r_d;
    prod_t            p2_q, p_d;
    q8_t              d3_q, d_d;
    fc_cfg_t          cfg_q, cfg_d, cfg_in;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             advance;
    logic             out_hs;
    logic             cfg_ok;
    acc_t             sum;
    logic [15:0]      q16;
    logic [15:0]      z16;

    assign advance = !v3_q || i_ready;
    assign o_ready = advance;
    assign o_valid = v3_q;
    assign o_data  = d3_q;
    assign o_busy  = v1_q || v2_q || v3_q;
    assign o_cfg_err = err_q;
    assign out_hs  = v3_q && i_ready;
    assign o_last  = v3_q && (cnt_q == cfg_q.count - CNT_W'(1));
    assign cfg_ok  = !o_busy && !i_valid;

    assign cfg_in = '{
        relu_en: i_cfg_relu_en,
        mult:    i_cfg_mult,
        shift:   i_cfg_shift,
        out_zp:  i_cfg_out_zp,
        count:   i_cfg_count
    };

    // cfg only changes while idle, so every stage may read cfg_q directly
    always_comb begin
        sum = i_acc + i_bias;
        r_d = (cfg_q.relu_en && sum[ACC_W-1]) ? '0 : sum;
        p_d = prod_t'(r1_q) * prod_t'($signed(cfg_q.mult));
        z16 = q16 + {{8{cfg_q.out_zp[OUT_W-1]}}, cfg_q.out_zp};
        d_d = z16[OUT_W-1:0];
    end

    fc_round_shift u_rs (
        .p_i     (p2_q),
        .shift_i (cfg_q.shift),
        .q_o     (q16)
    );

    always_comb begin
        cfg_d = cfg_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (out_hs) begin
            cnt_d = o_last ? '0 : cnt_q + CNT_W'(1);
        end
        if (i_cfg_load) begin
            if (cfg_ok) begin
                cfg_d = cfg_in;
                cnt_d = '0;
                err_d = !cfg_legal(cfg_in);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            r1_q  <= '0;
            p2_q  <= '0;
            d3_q  <= '0;
            cfg_q <= CFG_RST;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (advance) begin
                v1_q <= i_valid;
                r1_q <= r_d;
                v2_q <= v1_q;
                p2_q <= p_d;
                v3_q <= v2_q;
                d3_q <= d_d;
            end
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_fc_requant_stage.sv
// Bench for fc_requant_stage: vector table, scoreboarded streams,
// config rejection and mid-stream reset.
module tb_fc_requant_stage;

    logic        clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_acc;
    logic [31:0] i_bias;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_data;
    logic        o_last;
    logic        i_cfg_load;
    logic        i_cfg_relu_en;
    logic [31:0] i_cfg_mult;
    logic [31:0] i_cfg_shift;
    logic [7:0]  i_cfg_out_zp;
    logic [15:0] i_cfg_count;
    logic        o_busy;
    logic        o_cfg_err;

    fc_requant_stage dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_acc         (i_acc),
        .i_bias        (i_bias),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_last        (o_last),
        .i_cfg_load    (i_cfg_load),
        .i_cfg_relu_en (i_cfg_relu_en),
        .i_cfg_mult    (i_cfg_mult),
        .i_cfg_shift   (i_cfg_shift),
        .i_cfg_out_zp  (i_cfg_out_zp),
        .i_cfg_count   (i_cfg_count),
        .o_busy        (o_busy),
        .o_cfg_err     (o_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    typedef struct {
        bit         relu;
        int         mult;
        int         shift;
        int         zp;
        int         acc;
        int         bias;
        logic [7:0] exp;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[8];

    int total = 0;
    int bad   = 0;

    bit m_relu;
    int m_mult;
    int m_shift;
    int m_zp;
    int m_count;
    int exp_cnt;

    localparam int P30 = 1073741824;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [7:0] model(input int acc, input int bias);
        int         s;
        longint     p;
        longint     q;
        int         ts;
        logic [7:0] r;
        s = acc + bias;
        if (m_relu && s < 0) s = 0;
        p  = longint'(s) * longint'(m_mult);
        ts = 31 - m_shift;
        q  = (p + (longint'(1) <<< (ts - 1))) >>> ts;
        r  = q[7:0] + m_zp[7:0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_cfg(input bit relu, input int mult, input int shift,
                            input int zp, input int cnt, input bit track);
        i_cfg_relu_en = relu;
        i_cfg_mult    = mult;
        i_cfg_shift   = shift;
        i_cfg_out_zp  = zp[7:0];
        i_cfg_count   = cnt[15:0];
        i_cfg_load    = 1'b1;
        step();
        i_cfg_load    = 1'b0;
        if (track) begin
            m_relu  = relu;
            m_mult  = mult;
            m_shift = shift;
            m_zp    = zp;
            m_count = cnt;
            exp_cnt = 0;
        end
    endtask

    // one cycle-accurate loop: drive, scoreboard in/out handshakes, advance
    task automatic run(input int nb, input int s_lo, input int s_hi, input int nexp);
        int   k = 0;
        int   nout = 0;
        int   c = 0;
        int   a;
        int   b;
        exp_t e;
        while ((k < nb || nout < nexp) && c < 300) begin
            a = int'($urandom_range(0, 600)) - 300;
            b = int'($urandom_range(0, 100)) - 50;
            i_valid = (k < nb);
            i_acc   = a;
            i_bias  = b;
            i_ready = !(c >= s_lo && c < s_hi);
            #1;
            if (o_valid && !i_ready) chk("stall_ready", o_ready, 0);
            if (i_valid && o_ready) begin
                e.d = model(a, b);
                e.l = (exp_cnt == m_count - 1);
                exp_cnt = e.l ? 0 : exp_cnt + 1;
                sbq.push_back(e);
                k++;
            end
            if (o_valid && i_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_size", sbq.size(), 1);
                end else begin
                    e = sbq.pop_front();
                    chk("s_data", o_data, e.d);
                    chk("s_last", o_last, e.l);
                end
                nout++;
            end
            step();
            c++;
        end
        i_valid = 1'b0;
        chk("run_in", k, nb);
        chk("run_out", nout, nexp);
    endtask

    initial begin
        int lat;
        int stale;

        vt[0] = '{1, P30,   0, -128,       -500, 100, 8'h80};
        vt[1] = '{1, P30,   0, -128,        200,   0, 8'hE4};
        vt[2] = '{0, P30,   0,    5,       -201,   0, 8'hA1};
        vt[3] = '{1, P30,   0,    0,       1000,   0, 8'hF4};
        vt[4] = '{1, P30,   5,    0,          3,   0, 8'h30};
        vt[5] = '{1, P30, -31,    7, 2147483647,   0, 8'h07};
        vt[6] = '{0,   1,  30,    0,         -3,   0, 8'hFF};
        vt[7] = '{0, P30,   0,    0, 2147483647,   3, 8'h01};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_acc = '0;
        i_bias = '0;
        i_ready = 1'b1;
        i_cfg_load = 1'b0;
        i_cfg_relu_en = 1'b1;
        i_cfg_mult = '0;
        i_cfg_shift = '0;
        i_cfg_out_zp = '0;
        i_cfg_count = 16'd1;
        m_relu = 1;
        m_mult = 0;
        m_shift = 0;
        m_zp = 0;
        m_count = 1;
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_last", o_last, 0);
        chk("rst_err", o_cfg_err, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_ready, 1);

        for (int i = 0; i < 8; i++) begin
            load_cfg(vt[i].relu, vt[i].mult, vt[i].shift, vt[i].zp, 1, 1);
            chk("v_err", o_cfg_err, 0);
            i_valid = 1'b1;
            i_acc   = vt[i].acc;
            i_bias  = vt[i].bias;
            i_ready = 1'b1;
            chk("v_ready", o_ready, 1);
            step();
            i_valid = 1'b0;
            lat = 1;
            while (!o_valid && lat < 10) begin
                step();
                lat++;
            end
            chk("v_lat", lat, 3);
            chk("v_data", o_data, vt[i].exp);
            chk("v_model", o_data, model(vt[i].acc, vt[i].bias));
            chk("v_last", o_last, 1);
            step();
            chk("v_drain", o_valid, 0);
        end

        // 10-beat layer with a 5-cycle downstream stall
        load_cfg(1, P30, 4, -3, 10, 1);
        run(10, 5, 10, 10);
        chk("sb_empty", sbq.size(), 0);
        chk("idle_busy", o_busy, 0);

        // illegal configs load but flag; legal load clears the flag
        load_cfg(1, P30, 31, 0, 4, 1);
        chk("err_shift", o_cfg_err, 1);
        load_cfg(1, P30, 0, 0, 4, 1);
        chk("err_clear", o_cfg_err, 0);
        load_cfg(1, P30, 0, 0, 0, 1);
        chk("err_count", o_cfg_err, 1);

        // load while busy is rejected and old cfg keeps being applied
        load_cfg(1, 536870912, 2, 1, 10, 1);
        chk("err_clear2", o_cfg_err, 0);
        run(3, 0, 1000, 0);
        chk("busy_full", o_busy, 1);
        load_cfg(0, 0, 0, 0, 1, 0);
        chk("err_busy", o_cfg_err, 1);
        run(0, 0, 0, 3);
        chk("sb_empty2", sbq.size(), 0);

        // reset mid-stream drops in-flight beats
        run(3, 0, 1000, 0);
        i_rst_n = 1'b0;
        step();
        chk("mrst_valid", o_valid, 0);
        chk("mrst_busy", o_busy, 0);
        chk("mrst_err", o_cfg_err, 0);
        i_rst_n = 1'b1;
        sbq.delete();
        m_relu = 1;
        m_mult = 0;
        m_shift = 0;
        m_zp = 0;
        m_count = 1;
        exp_cnt = 0;
        i_ready = 1'b1;
        stale = 0;
        for (int j = 0; j < 6; j++) begin
            if (o_valid || o_busy) stale++;
            step();
        end
        chk("no_stale", stale, 0);

        // layer of 3 wraps twice inside a 7-beat stream
        load_cfg(0, P30, 1, 9, 3, 1);
        run(7, 2, 4, 7);
        chk("sb_empty3", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
